// File: rtl/arb_pkg.sv
//------------------------------------------------------------------------------
// arb_pkg
// Shared types for the ibus/dbus memory arbiter: bus request/response structs
// for the core side (ibus, dbus) and the memory side (cbus), FSM state and
// owner enums, and the request translation helpers used at grant time.
// Optional feature macro used by the consumers of this package: ARB_RR_EN.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package arb_pkg;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int IDATA_W = 32;
   localparam int STRB_W  = DATA_W / 8;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic               addr_ok;
      logic               data_ok;
      logic [IDATA_W-1:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic              valid;
      logic              is_write;
      msize_t            size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } cbus_req_t;

   typedef struct packed {
      logic              ok;
      logic [DATA_W-1:0] data;
   } cbus_resp_t;

   // Instruction fetches are always 4-byte reads.
   function automatic cbus_req_t ibus_to_cbus(input ibus_req_t r);
      cbus_req_t c;
      c          = '0;
      c.valid    = 1'b1;
      c.is_write = 1'b0;
      c.size     = MSIZE4;
      c.addr     = r.addr;
      return c;
   endfunction

   // A data access is a write whenever any byte lane is enabled.
   function automatic cbus_req_t dbus_to_cbus(input dbus_req_t r);
      cbus_req_t c;
      c.valid    = 1'b1;
      c.is_write = |r.strobe;
      c.size     = r.size;
      c.addr     = r.addr;
      c.strobe   = r.strobe;
      c.data     = r.data;
      return c;
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
//------------------------------------------------------------------------------
// mem_arb_select
// Combinational winner pick between the instruction and data requesters.
//   ivalid     in   instruction bus request pending
//   dvalid     in   data bus request pending
//   last_grant in   owner of the previous grant (only with ARB_RR_EN)
//   any_valid  out  at least one requester pending
//   winner     out  requester to grant this cycle
// Macro ARB_RR_EN: defined -> round-robin on contention; undefined -> dbus
// always wins on contention (the memory stage stalls the whole pipe, so
// serving dbus first avoids a fetch/load deadlock).
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arb_select
   import arb_pkg::*;
(
   input  logic       ivalid,
   input  logic       dvalid,
`ifdef ARB_RR_EN
   input  arb_owner_t last_grant,
`endif
   output logic       any_valid,
   output arb_owner_t winner
);

   always_comb begin
      any_valid = ivalid | dvalid;
      winner    = OWN_D;
`ifdef ARB_RR_EN
      if (ivalid && dvalid) begin
         winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
      end else if (ivalid) begin
         winner = OWN_I;
      end
`else
      if (ivalid && !dvalid) begin
         winner = OWN_I;
      end
`endif
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory port between the core's instruction bus and data bus.
// One requester is granted at a time; its request is latched and replayed to
// the memory side until the single-beat completion, then the response is
// returned to that requester for exactly one cycle.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   ireq   in   instruction request {valid, addr}
//   iresp  out  instruction response {addr_ok, data_ok, data[31:0]}
//   dreq   in   data request {valid, addr, size, strobe, data}
//   dresp  out  data response {addr_ok, data_ok, data[63:0]}
//   oreq   out  memory-side request {valid, is_write, size, addr, strobe, data}
//   oresp  in   memory-side response {ok, data[63:0]}
// Macro ARB_RR_EN: round-robin arbitration on contention (see mem_arb_select).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ARB_IDLE | no grant; a pending request is latched and granted this cycle
// ARB_BUSY | latched request driven on oreq until oresp.ok
// ARB_RESP | one-cycle addr_ok/data_ok pulse to the owner, then back to IDLE
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_bus_arbiter
   import arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  ibus_req_t  ireq,
   output ibus_resp_t iresp,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   arb_state_t        state;
   arb_owner_t        owner;
   cbus_req_t         req_q;
   logic [DATA_W-1:0] rdata_q;

   logic              any_valid;
   arb_owner_t        winner;

`ifdef ARB_RR_EN
   arb_owner_t        last_grant;
`endif

   mem_arb_select u_select (
      .ivalid     (ireq.valid),
      .dvalid     (dreq.valid),
`ifdef ARB_RR_EN
      .last_grant (last_grant),
`endif
      .any_valid  (any_valid),
      .winner     (winner)
   );

   // req_q.valid is the oreq valid bit: set at grant, cleared on completion,
   // so a reset mid-transfer drops it without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         owner      <= OWN_I;
         req_q      <= '0;
         rdata_q    <= '0;
`ifdef ARB_RR_EN
         last_grant <= OWN_I;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_valid) begin
                  owner <= winner;
                  req_q <= (winner == OWN_D) ? dbus_to_cbus(dreq) : ibus_to_cbus(ireq);
`ifdef ARB_RR_EN
                  last_grant <= winner;
`endif
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (oresp.ok) begin
                  rdata_q     <= oresp.data;
                  req_q.valid <= 1'b0;
                  state       <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign oreq = req_q;

   // The latched address (req_q.addr) picks the 32-bit lane for fetches.
   always_comb begin
      iresp = '0;
      dresp = '0;
      if (state == ARB_RESP) begin
         if (owner == OWN_I) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = req_q.addr[2] ? rdata_q[DATA_W-1:IDATA_W] : rdata_q[IDATA_W-1:0];
         end else begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps

module tb_mem_bus_arbiter;
   import arb_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   ibus_req_t  ireq;
   ibus_resp_t iresp;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   mem_bus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .ireq  (ireq),
      .iresp (iresp),
      .dreq  (dreq),
      .dresp (dresp),
      .oreq  (oreq),
      .oresp (oresp)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      logic [63:0] data;
   } sb_t;

   typedef struct {
      bit          is_d;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] wdata;
      int          k;
      logic [63:0] mem;
      bit          exp_wr;
      msize_t      exp_size;
      logic [7:0]  exp_strobe;
      logic [63:0] exp_odata;
      logic [63:0] exp_resp;
   } vec_t;

   sb_t         sb[$];
   sb_t         mon_e;
   vec_t        vecs[6];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          dok_cnt = 0;
   int          dok_cyc = 0;
   int          n_i = 0;
   int          n_d = 0;
   int          mem_k = 0;
   int          mem_cnt = 0;
   logic [63:0] mem_data = '0;
   bit          spur_ok = 1'b0;
   logic [63:0] spur_data = '0;
   bit          mon_prev = 1'b0;
   logic        mon_i;
   logic        mon_d;

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory side: ok on the (mem_k+1)-th cycle oreq.valid is seen; optional
   // spurious ok while no request is outstanding.
   initial begin
      oresp = '0;
      forever begin
         @(negedge clk);
         if (oreq.valid) begin
            oresp.ok   = (mem_cnt == mem_k);
            oresp.data = mem_data;
            mem_cnt++;
         end else begin
            mem_cnt    = 0;
            oresp.ok   = spur_ok;
            oresp.data = spur_data;
         end
      end
   end

   // Response monitor: pops the scoreboard on every data_ok and retires the
   // requester's valid when its last outstanding request completes.
   initial forever begin
      @(negedge clk);
      mon_i = iresp.data_ok;
      mon_d = dresp.data_ok;
      if (mon_prev) chk("dok_single_cycle", {mon_i, mon_d}, 2'b00);
      mon_prev = mon_i | mon_d;
      if (mon_i | mon_d) begin
         dok_cnt++;
         dok_cyc = cyc;
         chk("dok_exclusive", mon_i & mon_d, 1'b0);
         if (sb.size() == 0) begin
            chk("unexpected_dok", {mon_i, mon_d}, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            chk("dok_side", mon_d, mon_e.is_d);
            if (mon_e.is_d) begin
               chk("dresp_data", dresp.data, mon_e.data);
               chk("dresp_addr_ok", dresp.addr_ok, 1'b1);
               chk("iresp_quiet", iresp, '0);
            end else begin
               chk("iresp_data", iresp.data, mon_e.data[31:0]);
               chk("iresp_addr_ok", iresp.addr_ok, 1'b1);
               chk("dresp_quiet", dresp, '0);
            end
         end
         if (mon_i) begin
            if (n_i > 0) n_i--;
            if (n_i == 0) ireq.valid = 1'b0;
         end
         if (mon_d) begin
            if (n_d > 0) n_d--;
            if (n_d == 0) dreq.valid = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic drive_i(input logic [63:0] addr, input int cnt);
      ireq.addr  = addr;
      ireq.valid = 1'b1;
      n_i        = cnt;
   endtask

   task automatic drive_d(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                          input logic [63:0] data, input int cnt);
      dreq.addr   = addr;
      dreq.size   = size;
      dreq.strobe = strobe;
      dreq.data   = data;
      dreq.valid  = 1'b1;
      n_d         = cnt;
   endtask

   task automatic wait_dok(input int target, input int bound, input string name);
      int n;
      n = 0;
      while (dok_cnt < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, (dok_cnt >= target), 1'b1);
   endtask

   task automatic wait_oreq(input int bound, input string name);
      int n;
      n = 0;
      while (!oreq.valid && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, oreq.valid, 1'b1);
   endtask

   initial begin
      int          base;
      int          n0;
      int          t_d;
      int          t_i;
      int          nb;
      logic [7:0]  ord;
      logic [63:0] last_addr;
      cbus_req_t   snap;

      vecs[0] = '{1'b0, 64'h8000_0004, MSIZE8, 8'h00, 64'h0, 2, 64'h1111_2222_3333_4444,
                  1'b0, MSIZE4, 8'h00, 64'h0, 64'h0000_0000_1111_2222};
      vecs[1] = '{1'b0, 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 0, 64'h1111_2222_3333_4444,
                  1'b0, MSIZE4, 8'h00, 64'h0, 64'h0000_0000_3333_4444};
      vecs[2] = '{1'b1, 64'h8000_0010, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1, 64'h0123_4567_89AB_CDEF,
                  1'b1, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
      vecs[3] = '{1'b1, 64'h8000_1000, MSIZE8, 8'h00, 64'h0000_0000_0000_0055, 3, 64'hCAFE_F00D_0000_0001,
                  1'b0, MSIZE8, 8'h00, 64'h0000_0000_0000_0055, 64'hCAFE_F00D_0000_0001};
      vecs[4] = '{1'b1, 64'h8000_0107, MSIZE1, 8'h80, 64'hAB00_0000_0000_0000, 0, 64'h0F0F_0F0F_F0F0_F0F0,
                  1'b1, MSIZE1, 8'h80, 64'hAB00_0000_0000_0000, 64'h0F0F_0F0F_F0F0_F0F0};
      vecs[5] = '{1'b0, 64'h8000_00FC, MSIZE8, 8'h00, 64'h0, 5, 64'hAAAA_BBBB_CCCC_DDDD,
                  1'b0, MSIZE4, 8'h00, 64'h0, 64'h0000_0000_AAAA_BBBB};

      reset = 1'b0;
      ireq  = '0;
      dreq  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_oreq", oreq, '0);
      chk("rst_iresp", iresp, '0);
      chk("rst_dresp", dresp, '0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Reset asserted mid-BUSY on a dbus write
      mem_k    = 2;
      mem_data = 64'h0BAD_0BAD_0BAD_0BAD;
      base     = dok_cnt;
      drive_d(64'h8000_0010, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1);
      @(negedge clk);
      chk("t1_busy_valid", oreq.valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t1_valid_drop", oreq.valid, 1'b0);
      chk("t1_oreq_zero", oreq, '0);
      dreq = '0;
      n_d  = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("t1_no_dok", dok_cnt, base);
      chk("t1_idle", oreq.valid, 1'b0);

      // Simultaneous ibus + dbus load: dbus first, ibus regranted from IDLE
      mem_k    = 1;
      mem_data = 64'h1234_5678_9ABC_DEF0;
      base     = dok_cnt;
      sb.push_back('{1'b1, 64'h1234_5678_9ABC_DEF0});
      sb.push_back('{1'b0, 64'h0000_0000_1234_5678});
      drive_d(64'h8000_1000, MSIZE8, 8'h00, 64'h0, 1);
      drive_i(64'h8000_0004, 1);
      n0 = cyc;
      @(negedge clk);
      chk("t3_first_addr", oreq.addr, 64'h8000_1000);
      wait_dok(base + 1, 20, "t3_d_done");
      t_d = dok_cyc;
      wait_dok(base + 2, 20, "t3_i_done");
      t_i = dok_cyc;
      chk("t3_d_latency", t_d, n0 + 3);
      chk("t3_i_latency", t_i, n0 + 7);
      repeat (3) @(negedge clk);
      chk("t3_dok_count", dok_cnt, base + 2);

      // Both requesters continuously valid for several transfers
      mem_k    = 0;
      mem_data = 64'h7777_6666_5555_4444;
      base     = dok_cnt;
`ifdef ARB_RR_EN
      ord = 8'h55;
`else
      ord = 8'h0F;
`endif
      for (int j = 0; j < 8; j++) begin
         if (ord[j]) sb.push_back('{1'b1, 64'h7777_6666_5555_4444});
         else        sb.push_back('{1'b0, 64'h0000_0000_5555_4444});
      end
      drive_d(64'h8000_2000, MSIZE8, 8'h00, 64'h0, 4);
      drive_i(64'h8000_0008, 4);
      wait_dok(base + 8, 100, "t4_done");
      repeat (2) @(negedge clk);

      // Table-driven single transfers
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         mem_k    = vecs[v].k;
         mem_data = vecs[v].mem;
         base     = dok_cnt;
         sb.push_back('{vecs[v].is_d, vecs[v].exp_resp});
         if (vecs[v].is_d) drive_d(vecs[v].addr, vecs[v].size, vecs[v].strobe, vecs[v].wdata, 1);
         else              drive_i(vecs[v].addr, 1);
         n0 = cyc;
         @(negedge clk);
         chk($sformatf("v%0d_valid", v), oreq.valid, 1'b1);
         chk($sformatf("v%0d_is_write", v), oreq.is_write, vecs[v].exp_wr);
         chk($sformatf("v%0d_size", v), oreq.size, vecs[v].exp_size);
         chk($sformatf("v%0d_strobe", v), oreq.strobe, vecs[v].exp_strobe);
         chk($sformatf("v%0d_odata", v), oreq.data, vecs[v].exp_odata);
         chk($sformatf("v%0d_addr", v), oreq.addr, vecs[v].addr);
         wait_dok(base + 1, 40, $sformatf("v%0d_done", v));
         chk($sformatf("v%0d_latency", v), dok_cyc, n0 + 2 + vecs[v].k);
         @(negedge clk);
      end

      // Spurious ok while idle, then ibus address churn during a dbus grant
      repeat (2) @(negedge clk);
      base      = dok_cnt;
      spur_data = 64'hFFFF_0000_FFFF_0000;
      spur_ok   = 1'b1;
      repeat (3) @(negedge clk);
      spur_ok = 1'b0;
      chk("t6_spur_no_busy", oreq.valid, 1'b0);
      @(negedge clk);
      chk("t6_spur_no_dok", dok_cnt, base);

      mem_k    = 4;
      mem_data = 64'hA1A2_A3A4_B1B2_B3B4;
      snap          = '0;
      snap.valid    = 1'b1;
      snap.is_write = 1'b1;
      snap.size     = MSIZE2;
      snap.addr     = 64'h8000_3000;
      snap.strobe   = 8'h03;
      snap.data     = 64'h0000_0000_0000_5A5A;
      sb.push_back('{1'b1, 64'hA1A2_A3A4_B1B2_B3B4});
      sb.push_back('{1'b0, 64'h0000_0000_A1A2_A3A4});
      drive_d(64'h8000_3000, MSIZE2, 8'h03, 64'h0000_0000_0000_5A5A, 1);
      @(negedge clk);
      drive_i(64'h8000_0104, 1);
      nb = 0;
      while (oreq.valid && nb < 20) begin
         chk("t6_req_q_stable", oreq, snap);
         ireq.addr = 64'h8000_0204 + 64'(nb) * 64'h100;
         nb++;
         @(negedge clk);
      end
      chk("t6_busy_cycles", nb, 5);
      last_addr = ireq.addr;
      wait_oreq(10, "t6_i_granted");
      chk("t6_i_addr", oreq.addr, last_addr);
      wait_dok(base + 2, 30, "t6_done");
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
